// File: rtl/scr1_axi_arb_pkg.sv
// Shared AXI4 read-arbiter definitions: channel field widths, AR control
// struct, grant lock state and the master-index width helper.
package scr1_axi_arb_pkg;

    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;
    localparam int OUTST_W     = 4;

    typedef struct packed {
        logic [AXI_LEN_W-1:0]   len;
        logic [AXI_SIZE_W-1:0]  size;
        logic [AXI_BURST_W-1:0] burst;
    } ar_ctrl_t;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // A single master still needs one index bit so the slave-side ID is never empty.
    function automatic int idxWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scr1_axi_rd_arb_if.sv
// Bundle of N_MST upstream AXI4 read ports plus the single downstream read port.
// The arbiter uses the slave modport; the surrounding system uses master.
interface scr1_axi_rd_arb_if
    import scr1_axi_arb_pkg::*;
#(
    parameter int N_MST  = 2,
    parameter int ID_W   = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int IDX_W = idxWidth(N_MST);

    logic [N_MST-1:0][ID_W-1:0]        s_arid;
    logic [N_MST-1:0][ADDR_W-1:0]      s_araddr;
    logic [N_MST-1:0][AXI_LEN_W-1:0]   s_arlen;
    logic [N_MST-1:0][AXI_SIZE_W-1:0]  s_arsize;
    logic [N_MST-1:0][AXI_BURST_W-1:0] s_arburst;
    logic [N_MST-1:0]                  s_arvalid;
    logic [N_MST-1:0]                  s_arready;

    logic [N_MST-1:0][ID_W-1:0]        s_rid;
    logic [N_MST-1:0][DATA_W-1:0]      s_rdata;
    logic [N_MST-1:0][AXI_RESP_W-1:0]  s_rresp;
    logic [N_MST-1:0]                  s_rlast;
    logic [N_MST-1:0]                  s_rvalid;
    logic [N_MST-1:0]                  s_rready;

    logic [ID_W+IDX_W-1:0]             m_arid;
    logic [ADDR_W-1:0]                 m_araddr;
    logic [AXI_LEN_W-1:0]              m_arlen;
    logic [AXI_SIZE_W-1:0]             m_arsize;
    logic [AXI_BURST_W-1:0]            m_arburst;
    logic                              m_arvalid;
    logic                              m_arready;

    logic [ID_W+IDX_W-1:0]             m_rid;
    logic [DATA_W-1:0]                 m_rdata;
    logic [AXI_RESP_W-1:0]             m_rresp;
    logic                              m_rlast;
    logic                              m_rvalid;
    logic                              m_rready;

    modport slave (
        input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
        output s_arready,
        output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        input  s_rready,
        output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        input  m_arready,
        input  m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        output m_rready
    );

    modport master (
        output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
        input  s_arready,
        input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        output s_rready,
        input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        output m_arready,
        output m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        input  m_rready
    );

endinterface

// File: rtl/scr1_rr_arb.sv
// N-way round-robin arbiter whose grant freezes while a presented request
// waits for ready, so the downstream AR payload stays stable.
module scr1_rr_arb
    import scr1_axi_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idxWidth(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    input  logic             valid_i,
    input  logic             ready_i,
    output logic [IDX_W-1:0] grant_o
);

    arb_state_e       state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] lockIdx_q;

    function automatic logic [IDX_W-1:0] rrPick(input logic [N-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               cand;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && req[cand]) begin
                pick  = IDX_W'(cand);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign grant_o = (state_q == ARB_LOCKED) ? lockIdx_q : rrPick(req_i, ptr_q);
    assign ptr_d   = (grant_o == IDX_W'(N - 1)) ? '0 : grant_o + 1'b1;

    // A stalled request locks the grant; the handshake frees it and moves the pointer past the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_FREE;
            ptr_q     <= '0;
            lockIdx_q <= '0;
        end else if (valid_i && ready_i) begin
            state_q <= ARB_FREE;
            ptr_q   <= ptr_d;
        end else if (valid_i) begin
            state_q   <= ARB_LOCKED;
            lockIdx_q <= grant_o;
        end
    end

endmodule

// File: rtl/scr1_axi_rd_arb.sv
// AXI4 read-channel arbiter: N_MST masters share one slave port, master index
// is prepended to ARID and used to route R beats back.
module scr1_axi_rd_arb
    import scr1_axi_arb_pkg::*;
#(
    parameter int N_MST     = 2,
    parameter int ID_W      = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    scr1_axi_rd_arb_if.slave      bus,
    output logic [OUTST_W-1:0]    outst_cnt,
    output logic                  dec_err
);

    localparam int                 IDX_W   = idxWidth(N_MST);
    localparam logic [OUTST_W-1:0] MAX_CNT = OUTST_W'(MAX_OUTST);

    logic [IDX_W-1:0]   grant;
    logic               notFull;
    logic               arValid;
    logic               arHs;
    ar_ctrl_t           arCtrl;
    logic [ADDR_W-1:0]  arAddr;
    logic [N_MST-1:0]   arReady;

    logic [IDX_W-1:0]   rIdx;
    logic               rIdxHit;
    logic [N_MST-1:0]   rValidVec;
    logic               rReadySel;
    logic               rLastHs;
    logic [DATA_W-1:0]  rData;

    logic [OUTST_W-1:0] outstCnt_q, outstCnt_d;
    logic               decErr_q, decErr_d;

    scr1_rr_arb #(
        .N     (N_MST),
        .IDX_W (IDX_W)
    ) u_rr_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (bus.s_arvalid),
        .valid_i (arValid),
        .ready_i (bus.m_arready),
        .grant_o (grant)
    );

    assign notFull = (outstCnt_q < MAX_CNT);
    assign arValid = (|bus.s_arvalid) && notFull;
    assign arHs    = arValid && bus.m_arready;

    always_comb begin
        arCtrl       = '0;
        arCtrl.len   = bus.s_arlen[grant];
        arCtrl.size  = bus.s_arsize[grant];
        arCtrl.burst = bus.s_arburst[grant];
    end

    assign arAddr        = bus.s_araddr[grant];
    assign bus.m_arvalid = arValid;
    assign bus.m_arid    = {grant, bus.s_arid[grant]};
    assign bus.m_araddr  = arAddr;
    assign bus.m_arlen   = arCtrl.len;
    assign bus.m_arsize  = arCtrl.size;
    assign bus.m_arburst = arCtrl.burst;

    always_comb begin
        arReady = '0;
        if (arHs) begin
            arReady[grant] = 1'b1;
        end
    end
    assign bus.s_arready = arReady;

    // Beats tagged with a nonexistent master index are drained with ready held high.
    assign rIdx = bus.m_rid[ID_W+IDX_W-1:ID_W];

    always_comb begin
        rValidVec = '0;
        rIdxHit   = 1'b0;
        rReadySel = 1'b1;
        for (int i = 0; i < N_MST; i++) begin
            if (rIdx == IDX_W'(i)) begin
                rIdxHit      = 1'b1;
                rValidVec[i] = bus.m_rvalid;
                rReadySel    = bus.s_rready[i];
            end
        end
    end

    assign rData        = bus.m_rdata;
    assign bus.s_rvalid = rValidVec;
    assign bus.m_rready = rReadySel;
    assign bus.s_rid    = {N_MST{bus.m_rid[ID_W-1:0]}};
    assign bus.s_rdata  = {N_MST{rData}};
    assign bus.s_rresp  = {N_MST{bus.m_rresp}};
    assign bus.s_rlast  = {N_MST{bus.m_rlast}};

    assign rLastHs = bus.m_rvalid && rReadySel && bus.m_rlast;

    always_comb begin
        outstCnt_d = outstCnt_q;
        decErr_d   = decErr_q || (bus.m_rvalid && !rIdxHit);
        case ({arHs, rLastHs})
            2'b10: outstCnt_d = outstCnt_q + 1'b1;
            2'b01: begin
                if (outstCnt_q == '0) begin
                    decErr_d = 1'b1;
                end else begin
                    outstCnt_d = outstCnt_q - 1'b1;
                end
            end
            default: outstCnt_d = outstCnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstCnt_q <= '0;
            decErr_q   <= 1'b0;
        end else begin
            outstCnt_q <= outstCnt_d;
            decErr_q   <= decErr_d;
        end
    end

    assign outst_cnt = outstCnt_q;
    assign dec_err   = decErr_q;

endmodule
